// File: rtl/data_memory.sv
// Word-organised data memory for the MEM stage: synchronous write, same-cycle read.
// Byte addresses are rebased on BASE_ADDR and converted to word indices; reset clears every word.
module data_memory #(
   parameter int          WORD_COUNT = 64,
   parameter logic [31:0] BASE_ADDR  = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memWrite,
   input  logic        memRead,
   input  logic [31:0] Address,
   input  logic [31:0] writeData,
   output logic [31:0] readData
);

   localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

   logic [31:0]           word_index;
   logic                  in_range;
   logic                  write_en;
   logic                  read_en;
   logic [WORD_COUNT-1:0] wr_sel;
   logic [31:0]           mem_reg [WORD_COUNT];

   // Addresses below BASE_ADDR wrap to huge indices and so fall out of range.
   assign word_index = (Address - BASE_ADDR) >> 2;
   assign in_range   = (word_index < 32'(WORD_COUNT));
   assign write_en   = memWrite && in_range;
   assign read_en    = memRead && in_range;

   genvar gi;
   generate
      for (gi = 0; gi < WORD_COUNT; gi++) begin : g_wr_sel
         assign wr_sel[gi] = write_en && (word_index == 32'(gi));
      end
   endgenerate

   // Reset has priority, so a write in a reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < WORD_COUNT; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WORD_COUNT; i++) begin
            if (wr_sel[i]) begin
               mem_reg[i] <= writeData;
            end
         end
      end
   end

   always_comb begin
      readData = '0;
      if (read_en) begin
         readData = mem_reg[word_index[IDX_W-1:0]];
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected load values, a monitor pops and compares.
// Directed cases use literal expectations; random traffic uses a word-array reference model.
module tb_data_memory;

   logic        clk;
   logic        rst;
   logic        memWrite;
   logic        memRead;
   logic [31:0] Address;
   logic [31:0] writeData;
   logic [31:0] readData;

   data_memory #(.WORD_COUNT(64), .BASE_ADDR(32'd1024)) dut (
      .clk      (clk),
      .rst      (rst),
      .memWrite (memWrite),
      .memRead  (memRead),
      .Address  (Address),
      .writeData(writeData),
      .readData (readData)
   );

   typedef struct {
      string       name;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   event        sample_ev;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_mem [64];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a plain array of 64 words starting at byte address 1024.
   function automatic bit model_hit(input logic [31:0] a);
      return (a >= 32'd1024) && (a < 32'd1024 + 32'd256);
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      return int'((a - 32'd1024) / 32'd4);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic re);
      if (re && model_hit(a)) return model_mem[model_idx(a)];
      return 32'h0;
   endfunction

   task automatic model_edge();
      if (!rst) begin
         for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
      end else if (memWrite && model_hit(Address)) begin
         model_mem[model_idx(Address)] = writeData;
      end
   endtask

   task automatic drive(input logic r, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      rst       = r;
      memWrite  = we;
      memRead   = re;
      Address   = a;
      writeData = d;
   endtask

   task automatic clock_edge();
      @(posedge clk);
      model_edge();
   endtask

   task automatic expect_val(input string name, input logic [31:0] v);
      #1;
      exp_q.push_back('{name: name, data: v});
      ->sample_ev;
   endtask

   task automatic expect_model(input string name);
      #1;
      exp_q.push_back('{name: name, data: model_read(Address, memRead)});
      ->sample_ev;
   endtask

   // Monitor: readData is combinational, so it is valid whenever a sample is announced.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sample_without_expectation: readData=%h", readData);
         end else begin
            e = exp_q.pop_front();
            if (readData !== e.data) begin
               n_fail++;
               $display("FAIL %s: addr=%0d actual=%h required=%h", e.name, Address, readData, e.data);
            end else begin
               $display("ok   %s: addr=%0d readData=%h", e.name, Address, readData);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; memWrite = 1'b0; memRead = 1'b0; Address = '0; writeData = '0;
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;

      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0); clock_edge();
      drive(1'b1, 1'b0, 1'b1, 32'd1024, 32'd0); expect_val("reset_read_idx0", 32'h0);
      drive(1'b1, 1'b0, 1'b1, 32'd1276, 32'd0); expect_val("reset_read_idx63", 32'h0);

      drive(1'b1, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF); clock_edge();
      drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'h12345678); clock_edge();
      drive(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0); expect_val("readback_1028", 32'hDEADBEEF);
      drive(1'b1, 1'b0, 1'b1, 32'd1032, 32'd0); expect_val("readback_1032", 32'h12345678);
      drive(1'b1, 1'b0, 1'b1, 32'd1031, 32'd0); expect_val("readback_unaligned", 32'hDEADBEEF);
      drive(1'b1, 1'b0, 1'b0, 32'd1028, 32'd0); expect_val("read_gated", 32'h0);

      drive(1'b1, 1'b1, 1'b0, 32'd1280, 32'hAAAAAAAA); clock_edge();
      drive(1'b1, 1'b1, 1'b0, 32'd1020, 32'hAAAAAAAA); clock_edge();
      drive(1'b1, 1'b0, 1'b1, 32'd1024, 32'd0); expect_val("no_alias_idx0", 32'h0);
      drive(1'b1, 1'b0, 1'b1, 32'd1276, 32'd0); expect_val("no_alias_idx63", 32'h0);
      drive(1'b1, 1'b0, 1'b1, 32'd1280, 32'd0); expect_val("oor_read_1280", 32'h0);
      drive(1'b1, 1'b0, 1'b1, 32'd1020, 32'd0); expect_val("oor_read_1020", 32'h0);

      drive(1'b1, 1'b1, 1'b1, 32'd1028, 32'h0BADF00D); expect_val("rdw_before_edge", 32'hDEADBEEF);
      clock_edge(); expect_val("rdw_after_edge", 32'h0BADF00D);

      drive(1'b0, 1'b1, 1'b0, 32'd1028, 32'h55555555); clock_edge();
      drive(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0); expect_val("reset_beats_write", 32'h0);
      drive(1'b1, 1'b0, 1'b1, 32'd1032, 32'd0); expect_val("reset_cleared_1032", 32'h0);

      // Random mixed traffic around both ends of the window, read checked before each edge.
      for (int n = 0; n < 400; n++) begin
         logic        r;
         logic [31:0] a;
         r = ($urandom_range(0, 59) != 0);
         a = 32'd1000 + 32'($urandom_range(0, 300));
         drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), a, $urandom);
         expect_model($sformatf("random_%0d", n));
         clock_edge();
      end

      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
